pipe_alu: RTL and testbench

PIPE_ALU -- requirements
Module: pipe_alu

---
 rtl/pipe_alu_pkg.sv | 32 +++
 rtl/pipe_alu_addsub.sv | 23 ++
 rtl/pipe_alu.sv | 141 ++++++++++++++
 tb/tb_pipe_alu.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_alu_pkg.sv
// Shared types for the pipelined ALU: opcode and branch-select encodings plus FSM states.
package pipe_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ANDB = 3'b010,
    OP_XOR  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_FLAG = 3'b110,
    OP_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_ZERO     = 2'b00,
    BR_SIGN     = 2'b01,
    BR_OVF      = 2'b10,
    BR_ZERO_ALT = 2'b11
  } branch_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  function automatic logic is_shift(input alu_op_e op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/pipe_alu_addsub.sv
// Combinational add/subtract with zero, sign and signed-overflow flags.
module pipe_alu_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_z,
  output logic             o_n,
  output logic             o_v
);

  logic [WIDTH-1:0] w_b_eff;

  // Subtraction is a + ~b + 1, so overflow uses the inverted operand's sign.
  assign w_b_eff = i_sub ? ~i_b : i_b;
  assign o_sum   = i_a + w_b_eff + {{(WIDTH-1){1'b0}}, i_sub};
  assign o_z     = (o_sum == '0);
  assign o_n     = o_sum[WIDTH-1];
  assign o_v     = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (o_sum[WIDTH-1] != i_a[WIDTH-1]);

endmodule

// File: rtl/pipe_alu.sv
// Multi-cycle ALU with valid/ready on both sides; shifts move one bit per cycle.
//
// Handshake: a transfer happens on any rising edge where valid && ready are both
// high; valid must not depend on ready, and the producer holds its payload until
// the transfer.
module pipe_alu
  import pipe_alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [2:0]       alu_op,
  input  logic [1:0]       branch_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output state_e           dbg_state
);

  alu_op_e          w_op;
  branch_sel_e      w_sel;
  logic [SHAMT_W-1:0] w_shamt;
  logic             w_accept;
  logic             w_to_shift;
  logic [WIDTH-1:0] w_sum;
  logic             w_as_z, w_as_n, w_as_v;
  logic [WIDTH-1:0] w_res;
  logic             w_z, w_n, w_v;
  logic [WIDTH-1:0] w_shift_next;

  state_e           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_z, r_n, r_v;
  logic [WIDTH-1:0] r_shreg;
  logic [SHAMT_W-1:0] r_cnt;
  logic             r_shl;

  assign w_op       = alu_op_e'(alu_op);
  assign w_sel      = branch_sel_e'(branch_sel);
  assign w_shamt    = in2[SHAMT_W-1:0];
  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_to_shift = is_shift(w_op) && (w_shamt != '0);

  pipe_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_a   (in1),
    .i_b   (in2),
    .i_sub (w_op != OP_ADD),
    .o_sum (w_sum),
    .o_z   (w_as_z),
    .o_n   (w_as_n),
    .o_v   (w_as_v)
  );

  always_comb begin
    w_res = '0;
    w_z   = 1'b0;
    w_n   = 1'b0;
    w_v   = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: w_res = w_sum;
      OP_ANDB:        w_res = in1 & {WIDTH{in2[0]}};
      OP_XOR:         w_res = in1 ^ in2;
      OP_SHL, OP_SHR: w_res = in1;
      OP_FLAG: begin
        case (w_sel)
          BR_SIGN: w_res = {{(WIDTH-1){1'b0}}, w_as_n};
          BR_OVF:  w_res = {{(WIDTH-1){1'b0}}, w_as_v};
          default: w_res = {{(WIDTH-1){1'b0}}, w_as_z};
        endcase
      end
      default:        w_res = '0;
    endcase
    // FLAG reports the subtraction's flags, not those of its one-bit result.
    if ((w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_FLAG)) begin
      w_z = w_as_z;
      w_n = w_as_n;
      w_v = w_as_v;
    end else begin
      w_z = (w_res == '0);
      w_n = w_res[WIDTH-1];
    end
  end

  assign w_shift_next = r_shl ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
      r_v     <= 1'b0;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_shl   <= 1'b0;
    end else if (w_accept) begin
      if (w_to_shift) begin
        r_state <= ST_SHIFT;
        r_shreg <= in1;
        r_cnt   <= w_shamt;
        r_shl   <= (w_op == OP_SHL);
      end else begin
        r_state <= ST_DONE;
        r_out   <= w_res;
        r_z     <= w_z;
        r_n     <= w_n;
        r_v     <= w_v;
      end
    end else if (r_state == ST_SHIFT) begin
      r_shreg <= w_shift_next;
      r_cnt   <= r_cnt - 1'b1;
      if (r_cnt == SHAMT_W'(1)) begin
        r_state <= ST_DONE;
        r_out   <= w_shift_next;
        r_z     <= (w_shift_next == '0);
        r_n     <= w_shift_next[WIDTH-1];
        r_v     <= 1'b0;
      end
    end else if ((r_state == ST_DONE) && out_ready) begin
      r_state <= ST_IDLE;
    end
  end

  assign out_valid = (r_state == ST_DONE);
  assign out_val   = r_out;
  assign flag_z    = r_z;
  assign flag_n    = r_n;
  assign flag_v    = r_v;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pipe_alu.sv
// Self-checking bench for pipe_alu (WIDTH=8) against an arithmetic reference model.
module tb_pipe_alu;
  import pipe_alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic [2:0]   alu_op = '0;
  logic [1:0]   branch_sel = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_val;
  logic         flag_z, flag_n, flag_v;
  state_e       dbg_state;

  int checks = 0;
  int failures = 0;
  int low_cnt;
  logic [10:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  pipe_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .alu_op     (alu_op),
    .branch_sel (branch_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_val    (out_val),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_v     (flag_v),
    .dbg_state  (dbg_state)
  );

  // reference model: returns {v, n, z, value}
  function automatic logic [10:0] model(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic [1:0] sel);
    int sa, sb, s;
    logic [7:0] r;
    logic z, n, v, fz, fn, fv;
    sa = int'($signed(a));
    sb = int'($signed(b));
    s  = sa - sb;
    fv = (s > 127) || (s < -128);
    r  = a - b;
    fz = (r == 8'h00);
    fn = r[7];
    v  = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = a + b; v = (s > 127) || (s < -128); end
      3'd1: begin v = fv; end
      3'd2: r = b[0] ? a : 8'h00;
      3'd3: r = a ^ b;
      3'd4: r = a << b[2:0];
      3'd5: r = a >> b[2:0];
      3'd6: r = (sel == 2'd1) ? {7'd0, fn} : (sel == 2'd2) ? {7'd0, fv} : {7'd0, fz};
      default: r = 8'h00;
    endcase
    z = (r == 8'h00);
    n = r[7];
    if (op == 3'd6) begin
      z = fz; n = fn; v = fv;
    end
    return {v, n, z, r};
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [7:0] b);
    if (((op == 3'd4) || (op == 3'd5)) && (b[2:0] != 3'd0)) return int'(b[2:0]) + 1;
    return 1;
  endfunction

  // driver tasks (called at a negedge, return at a negedge)
  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] sel);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; alu_op = op; in1 = a; in2 = b; branch_sel = sel;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output logic [10:0] got, output int lat);
    lat = 1;
    low_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) low_cnt++;
      @(negedge clk);
      lat++;
    end
    got = {flag_v, flag_n, flag_z, out_val};
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] sel, output logic [10:0] got, output int lat);
    issue(op, a, b, sel);
    wait_result(got, lat);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_val !== 8'h00 || {flag_v, flag_n, flag_z} !== 3'b000 ||
        dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b val=%h vnz=%b%b%b exp valid=0 val=00 vnz=000",
               out_valid, out_val, flag_v, flag_n, flag_z);
    end
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_add_overflow();
    logic [10:0] got;
    int lat;
    out_ready = 1'b1;
    @(negedge clk);
    run_op(3'd0, 8'h7F, 8'h01, 2'd0, got, lat);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL add_latency: got %0d exp 1", lat);
    end
    checks++;
    if (got !== {1'b1, 1'b1, 1'b0, 8'h80}) begin
      failures++;
      $display("FAIL add_overflow: got %h exp %h", got, {1'b1, 1'b1, 1'b0, 8'h80});
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_deassert: out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_shift();
    logic [10:0] got;
    int lat;
    logic [7:0] exp_v [2];
    exp_v[0] = 8'h08;
    exp_v[1] = 8'h10;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      run_op(3'(4 + k), 8'h81, 8'h03, 2'd0, got, lat);
      checks++;
      if (low_cnt !== 3 || lat !== 4) begin
        failures++;
        $display("FAIL shift_timing op%0d: got low=%0d lat=%0d exp low=3 lat=4", 4 + k, low_cnt, lat);
      end
      checks++;
      if (got[7:0] !== exp_v[k] || got !== model(3'(4 + k), 8'h81, 8'h03, 2'd0)) begin
        failures++;
        $display("FAIL shift_value op%0d: got %h exp %h", 4 + k, got, model(3'(4 + k), 8'h81, 8'h03, 2'd0));
      end
    end
  endtask

  task automatic test_flag();
    logic [10:0] got;
    int lat;
    @(negedge clk);
    run_op(3'd6, 8'h05, 8'h05, 2'd0, got, lat);
    checks++;
    if (got !== {3'b001, 8'h01}) begin
      failures++;
      $display("FAIL flag_zero: got %h exp %h", got, {3'b001, 8'h01});
    end
    @(negedge clk);
    run_op(3'd6, 8'h05, 8'h05, 2'd1, got, lat);
    checks++;
    if (got !== {3'b001, 8'h00}) begin
      failures++;
      $display("FAIL flag_sign: got %h exp %h", got, {3'b001, 8'h00});
    end
  endtask

  task automatic test_boundaries();
    logic [2:0] t_op [7];
    logic [7:0] t_a  [7];
    logic [7:0] t_b  [7];
    logic [1:0] t_s  [7];
    logic [10:0] got;
    int lat;
    t_op[0] = 3'd1; t_a[0] = 8'h80; t_b[0] = 8'h01; t_s[0] = 2'd0;
    t_op[1] = 3'd1; t_a[1] = 8'h5A; t_b[1] = 8'h5A; t_s[1] = 2'd0;
    t_op[2] = 3'd2; t_a[2] = 8'hFF; t_b[2] = 8'hFE; t_s[2] = 2'd0;
    t_op[3] = 3'd4; t_a[3] = 8'hA5; t_b[3] = 8'h08; t_s[3] = 2'd0;
    t_op[4] = 3'd6; t_a[4] = 8'h80; t_b[4] = 8'h01; t_s[4] = 2'd2;
    t_op[5] = 3'd7; t_a[5] = 8'h33; t_b[5] = 8'h44; t_s[5] = 2'd0;
    t_op[6] = 3'd5; t_a[6] = 8'h80; t_b[6] = 8'h07; t_s[6] = 2'd3;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      run_op(t_op[i], t_a[i], t_b[i], t_s[i], got, lat);
      checks++;
      if (got !== model(t_op[i], t_a[i], t_b[i], t_s[i]) || lat !== model_lat(t_op[i], t_b[i])) begin
        failures++;
        $display("FAIL boundary_%0d: got %h lat %0d exp %h lat %0d", i, got, lat,
                 model(t_op[i], t_a[i], t_b[i], t_s[i]), model_lat(t_op[i], t_b[i]));
      end
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    issue(3'd3, 8'hF0, 8'h3C, 2'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_val !== 8'hCC) begin
        failures++;
        $display("FAIL stall_hold_%0d: got valid=%b ready=%b val=%h exp valid=1 ready=0 val=cc",
                 i, out_valid, in_ready, out_val);
      end
      in_valid = 1'b1; alu_op = 3'd0; in1 = 8'h01; in2 = 8'h01;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_val !== 8'hCC) begin
      failures++;
      $display("FAIL stall_release: got valid=%b val=%h exp valid=1 val=cc", out_valid, out_val);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || out_val !== 8'hCC) begin
      failures++;
      $display("FAIL stall_consumed_once: got valid=%b val=%h exp valid=0 val=cc", out_valid, out_val);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, b;
    logic [10:0] exp_v;
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      in_valid = 1'b1; alu_op = 3'd0; in1 = a; in2 = b; branch_sel = 2'd0;
      exp_q.push_back(model(3'd0, a, b, 2'd0));
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || {flag_v, flag_n, flag_z, out_val} !== exp_v) begin
        failures++;
        $display("FAIL stream_%0d: got valid=%b ready=%b res=%h exp valid=1 ready=1 res=%h",
                 i, out_valid, in_ready, {flag_v, flag_n, flag_z, out_val}, exp_v);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_end: out_valid got %b exp 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [10:0] got;
    int lat;
    int seen;
    @(negedge clk);
    issue(3'd4, 8'hFF, 8'h07, 2'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_val !== 8'h00 || {flag_v, flag_n, flag_z} !== 3'b000 ||
        in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_shift: got valid=%b val=%h vnz=%b%b%b ready=%b exp 0 00 000 1",
               out_valid, out_val, flag_v, flag_n, flag_z, in_ready);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL reset_no_result: out_valid cycles got %0d exp 0", seen);
    end
    run_op(3'd0, 8'h03, 8'h04, 2'd0, got, lat);
    checks++;
    if (got !== {3'b000, 8'h07} || lat !== 1) begin
      failures++;
      $display("FAIL reset_next_op: got %h lat %0d exp %h lat 1", got, lat, {3'b000, 8'h07});
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    logic [7:0] a, b;
    logic [1:0] sel;
    logic [10:0] got, exp_v;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      sel = 2'($urandom_range(0, 3));
      exp_q.push_back(model(op, a, b, sel));
      @(negedge clk);
      run_op(op, a, b, sel, got, lat);
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v || lat !== model_lat(op, b)) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h sel=%0d: got %h lat %0d exp %h lat %0d",
                 i, op, a, b, sel, got, lat, exp_v, model_lat(op, b));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_shift();
    test_flag();
    test_boundaries();
    test_stall();
    test_back_to_back();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
